// File: rtl/serial_pkg.sv
// Shared definitions for the serial pipeline stages.
// The serializer and the sequence detector both import this package.
package serial_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 8;

  // The caller left-justifies MSB-first words and right-justifies LSB-first words.
  // With that layout, idx always counts from the first bit sent.
  function automatic logic bit_sel(input logic [31:0] word, input logic [4:0] idx,
                                   input logic msb_first);
    return msb_first ? word[5'd31 - idx] : word[idx];
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register with a full flag.
// It is loaded on load and emptied on take; the parent never asserts both in the same cycle.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] word_reg;
  logic             full_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_reg <= '0;
      full_reg <= 1'b0;
    end else begin
      if (load) begin
        word_reg <= din;
        full_reg <= 1'b1;
      end else if (take) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign dout = word_reg;
  assign full = full_reg;

endmodule

// File: rtl/serial_word_serializer.sv
// Parallel-to-serial front end for the sequence detector: valid/ready word input,
// one bit per clock out, with a one-word holding register for gapless frames.
module serial_word_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             data_reg, data_next;
  logic             dv_reg, dv_next;
  logic             fl_reg, fl_next;
  logic [31:0]      aligned_next;
  logic             hold_full, hold_load, hold_take, accept;
  logic [WIDTH-1:0] hold_word;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .take  (hold_take),
    .din   (in_word),
    .dout  (hold_word),
    .full  (hold_full)
  );

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= SER_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      data_reg  <= IDLE_BIT;
      dv_reg    <= 1'b0;
      fl_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      dv_reg    <= dv_next;
      fl_reg    <= fl_next;
    end
  end

  // At the last-bit edge, the held word wins. A fresh word can bypass the holding
  // register only when the holding register is empty.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    hold_load  = 1'b0;
    hold_take  = 1'b0;
    case (state_reg)
      SER_IDLE: begin
        if (accept) begin
          shift_next = in_word;
          cnt_next   = '0;
          state_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (hold_full) begin
            shift_next = hold_word;
            hold_take  = 1'b1;
          end else if (accept) begin
            shift_next = in_word;
          end else begin
            state_next = SER_IDLE;
          end
        end else begin
          cnt_next  = cnt_reg + CNT_W'(1);
          hold_load = accept;
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  // The outputs are decoded from the next state so the registered bit lines up with its state.
  always_comb begin
    aligned_next = MSB_FIRST ? (32'(shift_next) << (32 - WIDTH)) : 32'(shift_next);
    data_next    = IDLE_BIT;
    dv_next      = 1'b0;
    fl_next      = 1'b0;
    if (state_next == SER_SHIFT) begin
      data_next = bit_sel(aligned_next, 5'(cnt_next), MSB_FIRST);
      dv_next   = 1'b1;
      fl_next   = (cnt_next == LAST_CNT);
    end
  end

  assign data       = data_reg;
  assign data_valid = dv_reg;
  assign frame_last = fl_reg;
  assign busy       = (state_reg == SER_SHIFT) | hold_full;

endmodule

// File: tb/tb_serial_word_serializer.sv
// Directed bench for serial_word_serializer.
// It uses an MSB-first instance and an LSB-first instance that share clock and reset.
module tb_serial_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] word_m, word_l;
  logic       valid_m, valid_l;
  logic       ready_m, ready_l, data_m, data_l, dv_m, dv_l, fl_m, fl_l, busy_m, busy_l;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  serial_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_word(word_m), .in_valid(valid_m), .in_ready(ready_m),
    .data(data_m), .data_valid(dv_m), .frame_last(fl_m), .busy(busy_m)
  );

  serial_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_word(word_l), .in_valid(valid_l), .in_ready(ready_l),
    .data(data_l), .data_valid(dv_l), .frame_last(fl_l), .busy(busy_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // seq lists the expected serial bits in send order; the leftmost bit is sent first.
  task automatic send_word(input string tag, input logic lsb, input logic [7:0] w,
                           input logic [7:0] seq);
    if (lsb) begin word_l = w; valid_l = 1'b1; end
    else     begin word_m = w; valid_m = 1'b1; end
    step();
    valid_l = 1'b0;
    valid_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_dv"},   lsb ? dv_l : dv_m, 1);
      chk({tag, "_bit"},  lsb ? data_l : data_m, seq[7-i]);
      chk({tag, "_last"}, lsb ? fl_l : fl_m, (i == 7));
      step();
    end
    chk({tag, "_end_dv"},   lsb ? dv_l : dv_m, 0);
    chk({tag, "_end_busy"}, lsb ? busy_l : busy_m, 0);
    chk({tag, "_end_data"}, lsb ? data_l : data_m, 0);
    $display("txn %s word=%h done", tag, w);
  endtask

  initial begin
    logic [23:0] seq24;
    logic [7:0]  words [3];
    int          idx;
    int          fl_count;
    logic        fire;
    logic        exp_ready;

    // 1: reset held for two clocks while in_valid is high
    reset = 1'b0; valid_m = 1'b1; word_m = 8'hB0; valid_l = 1'b0; word_l = 8'h00;
    step();
    step();
    chk("rst_dv", dv_m, 0);
    chk("rst_data", data_m, 0);
    chk("rst_last", fl_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_ready", ready_m, 1);
    reset = 1'b1; valid_m = 1'b0;
    step();
    chk("post_rst_dv", dv_m, 0);
    chk("post_rst_ready", ready_m, 1);
    $display("txn reset checked");

    // 2: single word, MSB first
    send_word("t2_b0", 1'b0, 8'hB0, 8'b1011_0000);

    // 3 and 4: three back-to-back words with in_valid held high
    words[0] = 8'hB0; words[1] = 8'h0B; words[2] = 8'hFF;
    seq24 = {8'hB0, 8'h0B, 8'hFF};
    idx = 0; fl_count = 0;
    word_m = words[0]; valid_m = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      fire = valid_m & ready_m;
      step();
      if (fire) begin
        idx++;
        if (idx < 3) word_m = words[idx];
        else valid_m = 1'b0;
      end
      exp_ready = !((cyc >= 1 && cyc <= 7) || (cyc >= 9 && cyc <= 15));
      chk("t3_dv", dv_m, 1);
      chk("t3_bit", data_m, seq24[23-cyc]);
      chk("t3_last", fl_m, ((cyc % 8) == 7));
      chk("t3_ready", ready_m, exp_ready);
      chk("t3_busy", busy_m, 1);
      if (fl_m) fl_count++;
      if (cyc == 8) chk("t4_not_taken", idx, 2);
      if (cyc == 9) chk("t4_taken", idx, 3);
    end
    step();
    chk("t3_end_dv", dv_m, 0);
    chk("t3_end_busy", busy_m, 0);
    chk("t3_fl_count", fl_count, 3);
    chk("t3_words_taken", idx, 3);
    $display("txn back_to_back words=3 frame_last=%0d", fl_count);

    // 5: reset at bit 4 of B0 while 0B sits in the holding register
    word_m = 8'hB0; valid_m = 1'b1;
    step();
    word_m = 8'h0B;
    step();
    valid_m = 1'b0;
    step();
    step();
    chk("t5_held_ready", ready_m, 0);
    chk("t5_bit3", data_m, 1);
    reset = 1'b0;
    step();
    chk("t5_rst_dv", dv_m, 0);
    chk("t5_rst_data", data_m, 0);
    chk("t5_rst_last", fl_m, 0);
    chk("t5_rst_busy", busy_m, 0);
    chk("t5_rst_ready", ready_m, 1);
    reset = 1'b1;
    step();
    chk("t5_no_held_word", dv_m, 0);
    $display("txn mid_frame_reset");
    send_word("t5_55", 1'b0, 8'h55, 8'b0101_0101);

    // 6: detector pattern in both bit orders
    send_word("t6_msb", 1'b0, 8'b1011_0110, 8'b1011_0110);
    send_word("t6_lsb", 1'b1, 8'b1011_0110, 8'b0110_1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
